frame_checksum_checker: RTL and testbench
=========================================

Name: frame_checksum_checker

Overview:
- Streaming successor to the combinational sensor-frame checksum check.
- Accepts a sensor frame one byte per handshake: N_DATA payload bytes followed by one checksum byte.
- Accumulates the checksum on the fly, validates it, and holds the last good payload for downstream registers.
- Sits between the serial bit/byte receiver and the display/UART path; adds sum/XOR modes, inter-byte timeout, resync and good/bad frame statistics.

Parameters:
- N_DATA, 4, payload bytes per frame (>=1); frame length is N_DATA+1 bytes.
- MODE, 0, checksum rule: 0 = 8-bit sum modulo 256, 1 = bytewise XOR.
- TIMEOUT, 1000, max idle cycles between accepted bytes inside a frame; 0 disables the timeout.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle resync pulse; aborts any partial frame.
- in_valid  in  1  in_byte is valid this cycle.
- in_byte  in  8  frame byte, first received byte first.
- in_ready  out  1  block can accept a byte this cycle.
- out_data  out  8*N_DATA  last good payload; first received byte at [7:0], byte k at [8k+7:8k].
- out_valid  out  1  one-cycle pulse: out_data updated with a new good frame.
- frame_error  out  1  one-cycle pulse: checksum mismatch.
- timeout_error  out  1  one-cycle pulse: frame aborted by timeout.
- good_count  out  CNT_W  saturating count of good frames.
- bad_count  out  CNT_W  saturating count of mismatched plus timed-out frames.

Behaviour:
- Reset: state IDLE; out_data, out_valid, frame_error, timeout_error, good_count, bad_count, byte index, accumulator and timeout counter all 0; in_ready = 1 in the cycle after reset.
- A byte is accepted when in_valid & in_ready.
- IDLE:
  - in_ready = 1.
  - Accepted byte is stored as payload byte 0 and becomes the accumulator (sum mode: acc = byte; XOR mode: acc = byte).
  - Index becomes 1 and the state moves to COLLECT. If N_DATA==1, the next byte is the checksum.
- COLLECT:
  - in_ready = 1.
  - While index < N_DATA, an accepted byte is stored at slot [index], then acc = acc + byte (mod 256) or acc ^ byte, and index increments.
  - When index == N_DATA, the accepted byte is latched as the checksum and the state moves to CHECK.
- CHECK (exactly one cycle):
  - in_ready = 0.
  - Compare acc with the latched checksum.
  - Equal: next cycle out_data <= payload buffer, out_valid = 1, good_count increments.
  - Not equal: next cycle frame_error = 1, bad_count increments, out_data unchanged.
  - Return to IDLE in both cases.
- Latency: if the checksum byte is accepted in cycle T, out_valid/frame_error is high in cycle T+2 for exactly one cycle. A new frame's first byte may be accepted in T+2.
- Timeout (TIMEOUT>0, COLLECT only):
  - The counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches TIMEOUT: timeout_error pulses next cycle, bad_count increments, state returns to IDLE, partial frame is discarded, out_data is unchanged.
  - The counter is held at 0 in IDLE/CHECK.
- frame_start:
  - In any state, discards the partial frame and clears index, accumulator and timeout counter.
  - No error pulse and no counter change.
  - If in_valid is high in the same cycle, that byte is accepted as byte 0 of the new frame (state COLLECT).
  - During CHECK, frame_start takes priority: the pending result is dropped.
- Counters saturate at 2^CNT_W-1; no wrap.
- Accumulator is exactly 8 bits; carries beyond bit 7 are discarded.
- Reset mid-frame: the frame is discarded and all state returns to reset values; no error pulse.
- out_valid, frame_error and timeout_error are mutually exclusive in any cycle.

Decomposition:
- Shared package frame_pkg holds:
  - the state enum {IDLE, COLLECT, CHECK};
  - constants CHK_MODE_SUM=0 and CHK_MODE_XOR=1;
  - BYTE_W=8.
- One sub-module, chk_accum:
  - MODE-parametrised 8-bit accumulator;
  - inputs clr, load, en, byte; output acc.
- FSM, payload buffer, timeout and counters stay in the top module.

Test Plan:
- Sum mode, N_DATA=4: bytes 0x35,0x00,0x18,0x00, checksum 0x4D, back-to-back -> out_valid in T+2, out_data=0x00180035, good_count=1.
- Same payload with checksum 0x4C -> frame_error pulse in T+2, out_data stays 0x00180035, bad_count=1, no out_valid.
- Wrap-around: 0xFF x4, checksum 0xFC -> good. MODE=1 with 0x12,0x34,0x56,0x78, checksum 0x08 -> good; checksum 0xFC in XOR mode -> frame_error.
- TIMEOUT=16: send 0x35,0x00, then idle 16 cycles -> timeout_error pulse, bad_count+1, state IDLE. A following full good frame is accepted normally.
- Send 3 bytes, then frame_start with in_valid=1 and byte 0x35, then the rest of a good frame -> one out_valid, no errors. Repeat with reset asserted after 2 bytes -> all outputs 0, next frame good.
- CNT_W=2: 5 good frames -> good_count saturates at 3. in_ready low exactly in the CHECK cycle; in_valid held high there is not accepted.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: shared FSM states, checksum modes and the per-byte checksum step
package frame_pkg;
  localparam int BYTE_W = 8;
  localparam int CHK_MODE_SUM = 0;
  localparam int CHK_MODE_XOR = 1;
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
  function automatic logic [BYTE_W-1:0] chk_step(input int mode, input logic [BYTE_W-1:0] a, input logic [BYTE_W-1:0] b);
    return mode == CHK_MODE_XOR ? a ^ b : a + b;
  endfunction
endpackage

// File: rtl/chk_accum.sv
// chk_accum: 8-bit running checksum, sum modulo 256 or bytewise XOR
module chk_accum import frame_pkg::*; #(
  parameter int MODE = CHK_MODE_SUM
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] acc_o
);
  // clear beats load beats accumulate
  always_ff @(posedge clk)
    if (clr) acc_o <= '0;
    else if (load) acc_o <= byte_i;
    else if (en) acc_o <= chk_step(MODE, acc_o, byte_i);
endmodule

// File: rtl/frame_checksum_checker.sv
// frame_checksum_checker: streaming frame receiver with checksum check, timeout, resync and statistics
module frame_checksum_checker import frame_pkg::*; #(
  parameter int N_DATA  = 4,
  parameter int MODE    = CHK_MODE_SUM,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic [BYTE_W-1:0]        in_byte,
  output logic                     in_ready,
  output logic [BYTE_W*N_DATA-1:0] out_data,
  output logic                     out_valid,
  output logic                     frame_error,
  output logic                     timeout_error,
  output logic [CNT_W-1:0]         good_count,
  output logic [CNT_W-1:0]         bad_count
);
  localparam int IW = $clog2(N_DATA + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [BYTE_W*N_DATA-1:0]   buf_q, buf_d, data_q, data_d;
  logic [BYTE_W-1:0]          chk_q, chk_d, acc;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic [CNT_W-1:0]           good_q, good_d, bad_q, bad_d;
  logic                       ov_q, ov_d, fe_q, fe_d, te_q, te_d;
  logic                       accept, load, en;
  assign in_ready      = state_q != CHECK || frame_start;
  assign accept        = in_valid && in_ready;
  assign out_data      = data_q;
  assign out_valid     = ov_q;
  assign frame_error   = fe_q;
  assign timeout_error = te_q;
  assign good_count    = good_q;
  assign bad_count     = bad_q;
  chk_accum #(.MODE(MODE)) u_acc (
    .clk   (clk),
    .clr   (reset || (frame_start && !accept)),
    .load  (load),
    .en    (en),
    .byte_i(in_byte),
    .acc_o (acc)
  );
  // frame FSM: collect payload, latch checksum, judge the frame, count outcomes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    chk_d   = chk_q;
    tcnt_d  = '0;
    data_d  = data_q;
    good_d  = good_q;
    bad_d   = bad_q;
    ov_d    = 1'b0;
    fe_d    = 1'b0;
    te_d    = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    if (frame_start) begin
      state_d = accept ? COLLECT : IDLE;
      idx_d   = accept ? IW'(1) : '0;
      load    = accept;
      if (accept) buf_d[BYTE_W-1:0] = in_byte;
    end else case (state_q)
      IDLE: if (accept) begin
        buf_d[BYTE_W-1:0] = in_byte;
        load    = 1'b1;
        idx_d   = IW'(1);
        state_d = COLLECT;
      end
      COLLECT: if (accept && idx_q < IW'(N_DATA)) begin
        buf_d[int'(idx_q)*BYTE_W +: BYTE_W] = in_byte;
        en    = 1'b1;
        idx_d = idx_q + 1'b1;
      end else if (accept) begin
        chk_d   = in_byte;
        state_d = CHECK;
      end else if (TIMEOUT > 0) begin
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_d == TW'(TIMEOUT)) begin
          te_d    = 1'b1;
          tcnt_d  = '0;
          idx_d   = '0;
          state_d = IDLE;
          if (bad_q != '1) bad_d = bad_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        idx_d   = '0;
        if (acc == chk_q) begin
          data_d = buf_q;
          ov_d   = 1'b1;
          if (good_q != '1) good_d = good_q + 1'b1;
        end else begin
          fe_d = 1'b1;
          if (bad_q != '1) bad_d = bad_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      chk_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      chk_q   <= chk_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
      te_q    <= te_d;
    end
endmodule

// File: tb/tb_frame_checksum_checker.sv
// tb_frame_checksum_checker: sum and XOR checkers fed one stream, scored against a frame-level model
module tb_frame_checksum_checker;
  localparam int N  = 4;
  localparam int TO = 16;
  typedef struct packed {
    logic [1:0][2:0]  k;
    logic [1:0][31:0] d;
    logic [1:0][15:0] g;
    logic [1:0][15:0] b;
    logic [31:0]      cyc;
  } ev_t;
  logic clk = 0, reset = 1, frame_start = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic rdy0, rdy1, ov0, ov1, fe0, fe1, te0, te1;
  logic [31:0] od0, od1;
  logic [15:0] gc0, bc0;
  logic [1:0] gc1, bc1;
  ev_t q[$];
  logic [7:0] cur[$];
  logic [7:0] fb[5];
  logic [31:0] dexp[2];
  int gexp[2], bexp[2];
  int gmax[2] = '{65535, 3};
  int checks = 0, errors = 0, cnt = 0, last = 0;
  logic exp_ready = 1, accd = 0, mon_en = 0;
  frame_checksum_checker #(.N_DATA(N), .MODE(0), .TIMEOUT(TO), .CNT_W(16)) u_sum (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .frame_error(fe0), .timeout_error(te0),
    .good_count(gc0), .bad_count(bc0));
  frame_checksum_checker #(.N_DATA(N), .MODE(1), .TIMEOUT(TO), .CNT_W(2)) u_xor (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .frame_error(fe1), .timeout_error(te1),
    .good_count(gc1), .bad_count(bc1));
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cnt);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", n, a, e, cnt);
    end
  endtask
  function automatic int sat(input int v, input int m);
    return v < m ? v + 1 : v;
  endfunction
  task automatic post(input ev_t e, input int c);
    for (int d = 0; d < 2; d++) begin
      e.d[d] = dexp[d];
      e.g[d] = 16'(gexp[d]);
      e.b[d] = 16'(bexp[d]);
    end
    e.cyc = 32'(c + 1);
    q.push_back(e);
  endtask
  task automatic model(input logic v, input logic [7:0] b, input logic fs, input logic rs);
    ev_t e;
    logic [7:0] s[2];
    logic [31:0] p;
    int c;
    c = cnt;
    e = '0;
    exp_ready = fs || cur.size() != N + 1;
    accd = v && !rs && exp_ready;
    if (rs) begin
      cur.delete();
      for (int d = 0; d < 2; d++) begin
        dexp[d] = 0;
        gexp[d] = 0;
        bexp[d] = 0;
      end
    end else if (fs) begin
      cur.delete();
      if (v) begin
        cur.push_back(b);
        last = c;
      end
    end else if (cur.size() == N + 1) begin
      s[0] = 0;
      s[1] = 0;
      p = 0;
      for (int i = 0; i < N; i++) begin
        s[0] = s[0] + cur[i];
        s[1] = s[1] ^ cur[i];
        p[8*i +: 8] = cur[i];
      end
      for (int d = 0; d < 2; d++)
        if (s[d] == cur[N]) begin
          dexp[d] = p;
          gexp[d] = sat(gexp[d], gmax[d]);
          e.k[d] = 3'b100;
        end else begin
          bexp[d] = sat(bexp[d], gmax[d]);
          e.k[d] = 3'b010;
        end
      post(e, c);
      cur.delete();
    end else if (v) begin
      cur.push_back(b);
      last = c;
    end else if (cur.size() > 0 && c - last == TO) begin
      for (int d = 0; d < 2; d++) begin
        bexp[d] = sat(bexp[d], gmax[d]);
        e.k[d] = 3'b001;
      end
      post(e, c);
      cur.delete();
    end
  endtask
  task automatic step(input logic v, input logic [7:0] b, input logic fs, input logic rs);
    @(posedge clk);
    #1;
    in_valid = v;
    in_byte = b;
    frame_start = fs;
    reset = rs;
    model(v, b, fs, rs);
  endtask
  task automatic gap(input int n);
    repeat (n) step(0, 8'($urandom), 0, 0);
  endtask
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    do begin
      step(1, b, 0, 0);
      n++;
    end while (!accd && n < 3);
  endtask
  task automatic fr(input logic [7:0] a0, a1, a2, a3, a4);
    fb = '{a0, a1, a2, a3, a4};
    for (int i = 0; i <= N; i++) send(fb[i]);
  endtask
  task automatic send_fb(input int gmx);
    for (int i = 0; i <= N; i++) begin
      gap($urandom_range(0, gmx));
      send(fb[i]);
    end
  endtask
  task automatic zero_check(input string n);
    @(negedge clk);
    chk({n, "_data_sum"}, od0, 0);
    chk({n, "_data_xor"}, od1, 0);
    chk({n, "_cnt_sum"}, {gc0, bc0}, 0);
    chk({n, "_cnt_xor"}, 32'({gc1, bc1}), 0);
    chk({n, "_pulses"}, 32'({ov0, fe0, te0, ov1, fe1, te1}), 0);
  endtask
  always @(negedge clk) if (mon_en) begin : mon
    ev_t e;
    chk("in_ready_sum", 32'(rdy0), 32'(exp_ready));
    chk("in_ready_xor", 32'(rdy1), 32'(exp_ready));
    if ({ov0, fe0, te0, ov1, fe1, te1} != 0 || (q.size() > 0 && q[0].cyc <= cnt)) begin
      if (q.size() == 0) chk("unexpected_pulse", 32'({ov0, fe0, te0, ov1, fe1, te1}), 0);
      else begin
        e = q.pop_front();
        chk("latency", cnt, e.cyc);
        chk("kind_sum", 32'({ov0, fe0, te0}), 32'(e.k[0]));
        chk("kind_xor", 32'({ov1, fe1, te1}), 32'(e.k[1]));
        chk("data_sum", od0, e.d[0]);
        chk("data_xor", od1, e.d[1]);
        chk("good_sum", 32'(gc0), 32'(e.g[0]));
        chk("good_xor", 32'(gc1), 32'(e.g[1]));
        chk("bad_sum", 32'(bc0), 32'(e.b[0]));
        chk("bad_xor", 32'(bc1), 32'(e.b[1]));
      end
    end
  end
  initial begin
    logic [7:0] sx, sa;
    int r;
    step(0, 0, 0, 1);
    mon_en = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    zero_check("reset");
    fr(8'h35, 8'h00, 8'h18, 8'h00, 8'h4D);
    fr(8'h35, 8'h00, 8'h18, 8'h00, 8'h4C);
    fr(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
    fr(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    fr(8'h12, 8'h34, 8'h56, 8'h78, 8'hFC);
    send(8'h35);
    send(8'h00);
    gap(TO + 4);
    fr(8'h35, 8'h00, 8'h18, 8'h00, 8'h4D);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    step(1, 8'h35, 1, 0);
    for (int i = 1; i <= N; i++) send(fb[i]);
    step(1, 8'h35, 1, 0);
    fb = '{8'h35, 8'h00, 8'h18, 8'h00, 8'h4D};
    for (int i = 1; i <= N; i++) send(fb[i]);
    step(1, 8'h35, 1, 0);
    for (int i = 1; i <= N; i++) send(fb[i]);
    gap(2);
    send(8'h44);
    send(8'h55);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    zero_check("midreset");
    fr(8'h35, 8'h00, 8'h18, 8'h00, 8'h4D);
    repeat (5) fr(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    for (int it = 0; it < 150; it++) begin
      sx = 0;
      sa = 0;
      for (int i = 0; i < N; i++) begin
        fb[i] = 8'($urandom);
        sa = sa + fb[i];
        sx = sx ^ fb[i];
      end
      r = $urandom_range(0, 3);
      fb[N] = r == 1 ? sx : r == 2 ? 8'($urandom) : sa;
      if (r == 3) begin
        send(8'($urandom));
        send(8'($urandom));
        step(1, fb[0], 1, 0);
        for (int i = 1; i <= N; i++) send(fb[i]);
      end else send_fb($urandom_range(0, 15) == 0 ? TO + 3 : 2);
    end
    gap(TO + 10);
    chk("drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
